partition_error_meter: RTL and testbench



---
 rtl/partition_error_meter.sv | 158 +++++++++++++++
 tb/tb_partition_error_meter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/partition_error_meter.sv
// Exhaustive-sweep error meter: drives every IN_W-bit vector to a partition pair and accumulates error metrics.
// Optional max-error tracking is built only when the ERR_MAX_EN macro is defined.
module partition_error_meter #(
    parameter int IN_W  = 7,
    parameter int OUT_W = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    output logic [IN_W-1:0]                      pi_out,
    input  logic [OUT_W-1:0]                     po_exact,
    input  logic [OUT_W-1:0]                     po_approx,
    output logic                                 busy,
    output logic                                 done,
    output logic [IN_W:0]                        mismatch_cnt,
    output logic [IN_W+$clog2(OUT_W+1)-1:0]      hd_sum,
    output logic [IN_W+OUT_W-1:0]                abs_err_sum,
    output logic [OUT_W-1:0]                     max_abs_err
);

    localparam int PC_W  = $clog2(OUT_W + 1);
    localparam int MM_W  = IN_W + 1;
    localparam int HD_W  = IN_W + PC_W;
    localparam int ABS_W = IN_W + OUT_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IN_W-1:0]    r_cnt;
    logic               w_start_sweep;
    logic               w_last_vec;

    logic               r_cap_vld;
    logic [OUT_W-1:0]   r_cap_exact;
    logic [OUT_W-1:0]   r_cap_approx;

    logic [OUT_W-1:0]   w_diff;
    logic [PC_W-1:0]    w_popcnt;
    logic [OUT_W-1:0]   w_abs_err;
    logic               w_ne;

    logic [MM_W-1:0]    r_mismatch_cnt;
    logic [HD_W-1:0]    r_hd_sum;
    logic [ABS_W-1:0]   r_abs_err_sum;

    // start is only honoured when no sweep is in flight
    assign w_start_sweep = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last_vec    = (r_cnt == {IN_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_SWEEP;
            S_SWEEP: if (w_last_vec) w_state_next = S_DRAIN;
            S_DRAIN: w_state_next = S_DONE;
            S_DONE:  if (start) w_state_next = S_SWEEP;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Vector counter doubles as pi_out; it is held at 0 outside SWEEP so pi_out reads 0 there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_start_sweep) begin
            r_cnt <= '0;
        end else if ((r_state == S_SWEEP) && !w_last_vec) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign pi_out = r_cnt;
    assign busy   = (r_state == S_SWEEP) || (r_state == S_DRAIN);
    assign done   = (r_state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_vld    <= 1'b0;
            r_cap_exact  <= '0;
            r_cap_approx <= '0;
        end else if (w_start_sweep) begin
            r_cap_vld    <= 1'b0;
        end else begin
            r_cap_vld <= (r_state == S_SWEEP);
            if (r_state == S_SWEEP) begin
                r_cap_exact  <= po_exact;
                r_cap_approx <= po_approx;
            end
        end
    end

    assign w_diff    = r_cap_exact ^ r_cap_approx;
    assign w_ne      = |w_diff;
    assign w_abs_err = (r_cap_exact >= r_cap_approx) ? (r_cap_exact - r_cap_approx)
                                                     : (r_cap_approx - r_cap_exact);

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < OUT_W; i++) begin
            w_popcnt = w_popcnt + {{(PC_W-1){1'b0}}, w_diff[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mismatch_cnt <= '0;
            r_hd_sum       <= '0;
            r_abs_err_sum  <= '0;
        end else if (w_start_sweep) begin
            r_mismatch_cnt <= '0;
            r_hd_sum       <= '0;
            r_abs_err_sum  <= '0;
        end else if (r_cap_vld) begin
            r_mismatch_cnt <= r_mismatch_cnt + {{(MM_W-1){1'b0}}, w_ne};
            r_hd_sum       <= r_hd_sum + {{IN_W{1'b0}}, w_popcnt};
            r_abs_err_sum  <= r_abs_err_sum + {{IN_W{1'b0}}, w_abs_err};
        end
    end

    assign mismatch_cnt = r_mismatch_cnt;
    assign hd_sum       = r_hd_sum;
    assign abs_err_sum  = r_abs_err_sum;

`ifdef ERR_MAX_EN
    logic [OUT_W-1:0] r_max_abs_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_abs_err <= '0;
        end else if (w_start_sweep) begin
            r_max_abs_err <= '0;
        end else if (r_cap_vld && (w_abs_err > r_max_abs_err)) begin
            r_max_abs_err <= w_abs_err;
        end
    end

    assign max_abs_err = r_max_abs_err;
`else
    assign max_abs_err = '0;
`endif

endmodule

// File: tb/tb_partition_error_meter.sv
// Randomized self-checking bench for partition_error_meter; partitions are modelled as lookup tables
// and the expected metrics are recomputed from the vector list with plain arithmetic.
module tb_partition_error_meter;

    localparam int IN_W  = 7;
    localparam int OUT_W = 4;
    localparam int NV    = 1 << IN_W;
`ifdef ERR_MAX_EN
    localparam bit MAX_EN = 1'b1;
`else
    localparam bit MAX_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [IN_W-1:0]  pi_out;
    logic [OUT_W-1:0] po_exact;
    logic [OUT_W-1:0] po_approx;
    logic             busy;
    logic             done;
    logic [IN_W:0]    mismatch_cnt;
    logic [IN_W+2:0]  hd_sum;
    logic [IN_W+OUT_W-1:0] abs_err_sum;
    logic [OUT_W-1:0] max_abs_err;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;
    logic [OUT_W-1:0] lut_e [NV];
    logic [OUT_W-1:0] lut_a [NV];

    int exp_mm, exp_hd, exp_abs, exp_max;

    partition_error_meter #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .pi_out       (pi_out),
        .po_exact     (po_exact),
        .po_approx    (po_approx),
        .busy         (busy),
        .done         (done),
        .mismatch_cnt (mismatch_cnt),
        .hd_sum       (hd_sum),
        .abs_err_sum  (abs_err_sum),
        .max_abs_err  (max_abs_err)
    );

    always #5 clk = ~clk;

    // Partition pair under evaluation, selected by mode
    always_comb begin
        po_exact  = pi_out[3:0];
        po_approx = pi_out[3:0];
        case (mode)
            1: po_approx = 4'd0;
            2: po_approx = pi_out[3:0] ^ 4'b0001;
            3: begin
                po_exact  = lut_e[pi_out];
                po_approx = lut_a[pi_out];
            end
            default: ;
        endcase
    end

    function automatic int model_e(int v);
        if (mode == 3) return int'(lut_e[v]);
        return v % 16;
    endfunction

    function automatic int model_a(int v);
        case (mode)
            1: return 0;
            2: return (v % 16) ^ 1;
            3: return int'(lut_a[v]);
            default: return v % 16;
        endcase
    endfunction

    task automatic compute_model();
        int e, a, d, mx;
        exp_mm = 0; exp_hd = 0; exp_abs = 0; mx = 0;
        for (int v = 0; v < NV; v++) begin
            e = model_e(v);
            a = model_a(v);
            d = (e > a) ? e - a : a - e;
            if (e != a) exp_mm++;
            exp_hd  += $countones(e ^ a);
            exp_abs += d;
            if (d > mx) mx = d;
        end
        exp_max = MAX_EN ? mx : 0;
    endtask

    task automatic fill_luts();
        for (int i = 0; i < NV; i++) begin
            lut_e[i] = 4'($urandom);
            lut_a[i] = ($urandom_range(0, 3) == 0) ? lut_e[i] : 4'($urandom);
        end
    endtask

    // Runs one sweep from a start pulse (or held start); reports edges from E0 to done and sequencing errors.
    task automatic run_sweep(input bit hold, output int edges, output int seq_err);
        int exp_pi;
        @(negedge clk);
        start   = 1'b1;
        edges   = -1;
        seq_err = 0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (done) begin
                edges = c - 1;
                break;
            end
            exp_pi = (c - 1 < NV) ? c - 1 : 0;
            if (pi_out !== 7'(exp_pi)) seq_err++;
            if (busy !== 1'b1) seq_err++;
        end
        $display("sweep mode=%0d edges=%0d seq_err=%0d mm=%0d hd=%0d abs=%0d max=%0d",
                 mode, edges, seq_err, mismatch_cnt, hd_sum, abs_err_sum, max_abs_err);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; mode = 0;
        repeat (2) @(negedge clk);
        checks++; if (pi_out !== '0) begin failures++; $display("FAIL reset_pi: got %0d expected 0", pi_out); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", busy, done); end
        checks++; if (mismatch_cnt !== '0 || hd_sum !== '0) begin failures++; $display("FAIL reset_mm_hd: got %0d %0d expected 0 0", mismatch_cnt, hd_sum); end
        checks++; if (abs_err_sum !== '0 || max_abs_err !== '0) begin failures++; $display("FAIL reset_abs_max: got %0d %0d expected 0 0", abs_err_sum, max_abs_err); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL idle_no_start: got busy=%b done=%b expected 0 0", busy, done); end
    endtask

    task automatic test_identical();
        int edges, seq_err;
        mode = 0;
        run_sweep(1'b0, edges, seq_err);
        checks++; if (edges != 129) begin failures++; $display("FAIL identical_latency: got %0d expected 129", edges); end
        checks++; if (seq_err != 0) begin failures++; $display("FAIL identical_sequence: got %0d errors expected 0", seq_err); end
        checks++; if (mismatch_cnt !== '0 || hd_sum !== '0) begin failures++; $display("FAIL identical_mm_hd: got %0d %0d expected 0 0", mismatch_cnt, hd_sum); end
        checks++; if (abs_err_sum !== '0 || max_abs_err !== '0) begin failures++; $display("FAIL identical_abs_max: got %0d %0d expected 0 0", abs_err_sum, max_abs_err); end
        repeat (5) @(negedge clk);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL done_hold: got done=%b busy=%b expected 1 0", done, busy); end
    endtask

    task automatic test_zero_approx();
        int edges, seq_err;
        mode = 1;
        run_sweep(1'b0, edges, seq_err);
        checks++; if (edges != 129) begin failures++; $display("FAIL zero_latency: got %0d expected 129", edges); end
        checks++; if (mismatch_cnt !== 8'd120) begin failures++; $display("FAIL zero_mm: got %0d expected 120", mismatch_cnt); end
        checks++; if (hd_sum !== 10'd256) begin failures++; $display("FAIL zero_hd: got %0d expected 256", hd_sum); end
        checks++; if (abs_err_sum !== 11'd960) begin failures++; $display("FAIL zero_abs: got %0d expected 960", abs_err_sum); end
        checks++; if (int'(max_abs_err) != (MAX_EN ? 15 : 0)) begin failures++; $display("FAIL zero_max: got %0d expected %0d", max_abs_err, MAX_EN ? 15 : 0); end
    endtask

    task automatic test_lsb_flip();
        int edges, seq_err;
        mode = 2;
        run_sweep(1'b0, edges, seq_err);
        checks++; if (mismatch_cnt !== 8'd128) begin failures++; $display("FAIL flip_mm: got %0d expected 128", mismatch_cnt); end
        checks++; if (hd_sum !== 10'd128) begin failures++; $display("FAIL flip_hd: got %0d expected 128", hd_sum); end
        checks++; if (abs_err_sum !== 11'd128) begin failures++; $display("FAIL flip_abs: got %0d expected 128", abs_err_sum); end
        checks++; if (int'(max_abs_err) != (MAX_EN ? 1 : 0)) begin failures++; $display("FAIL flip_max: got %0d expected %0d", max_abs_err, MAX_EN ? 1 : 0); end
    endtask

    task automatic test_random();
        int edges, seq_err;
        for (int r = 0; r < 3; r++) begin
            mode = 3;
            fill_luts();
            compute_model();
            run_sweep(1'b0, edges, seq_err);
            checks++; if (edges != 129 || seq_err != 0) begin failures++; $display("FAIL rand%0d_timing: got edges=%0d seq_err=%0d expected 129 0", r, edges, seq_err); end
            checks++; if (int'(mismatch_cnt) != exp_mm) begin failures++; $display("FAIL rand%0d_mm: got %0d expected %0d", r, mismatch_cnt, exp_mm); end
            checks++; if (int'(hd_sum) != exp_hd) begin failures++; $display("FAIL rand%0d_hd: got %0d expected %0d", r, hd_sum, exp_hd); end
            checks++; if (int'(abs_err_sum) != exp_abs) begin failures++; $display("FAIL rand%0d_abs: got %0d expected %0d", r, abs_err_sum, exp_abs); end
            checks++; if (int'(max_abs_err) != exp_max) begin failures++; $display("FAIL rand%0d_max: got %0d expected %0d", r, max_abs_err, exp_max); end
        end
    endtask

    task automatic test_back_to_back();
        int edges, seq_err;
        bit seen_done;
        mode = 3;
        fill_luts();
        compute_model();
        run_sweep(1'b1, edges, seq_err);
        checks++; if (edges != 129) begin failures++; $display("FAIL held_latency: got %0d expected 129", edges); end
        checks++; if (seq_err != 0) begin failures++; $display("FAIL held_sequence: got %0d errors expected 0", seq_err); end
        checks++; if (int'(mismatch_cnt) != exp_mm || int'(abs_err_sum) != exp_abs) begin failures++; $display("FAIL held_metrics: got mm=%0d abs=%0d expected %0d %0d", mismatch_cnt, abs_err_sum, exp_mm, exp_abs); end
        // start is still high: the next edge restarts from DONE with a new partition pair
        mode = 1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL restart_flags: got done=%b busy=%b expected 0 1", done, busy); end
        checks++; if (mismatch_cnt !== '0 || hd_sum !== '0 || abs_err_sum !== '0 || max_abs_err !== '0) begin failures++; $display("FAIL restart_clear: got %0d %0d %0d %0d expected 0 0 0 0", mismatch_cnt, hd_sum, abs_err_sum, max_abs_err); end
        seen_done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done) begin seen_done = 1'b1; break; end
        end
        checks++; if (!seen_done) begin failures++; $display("FAIL restart_timeout: got no done expected done"); end
        checks++; if (mismatch_cnt !== 8'd120 || hd_sum !== 10'd256 || abs_err_sum !== 11'd960) begin failures++; $display("FAIL restart_metrics: got %0d %0d %0d expected 120 256 960", mismatch_cnt, hd_sum, abs_err_sum); end
    endtask

    task automatic test_reset_midsweep();
        int edges, seq_err;
        bit hit;
        mode = 3;
        fill_luts();
        compute_model();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (pi_out == 7'd50) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!hit) begin failures++; $display("FAIL mid_reach50: got pi=%0d expected 50", pi_out); end
        rst_n = 1'b0;
        #1;
        checks++; if (pi_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mid_reset_ctl: got pi=%0d busy=%b done=%b expected 0 0 0", pi_out, busy, done); end
        checks++; if (mismatch_cnt !== '0 || hd_sum !== '0 || abs_err_sum !== '0 || max_abs_err !== '0) begin failures++; $display("FAIL mid_reset_acc: got %0d %0d %0d %0d expected 0 0 0 0", mismatch_cnt, hd_sum, abs_err_sum, max_abs_err); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0 || pi_out !== '0) begin failures++; $display("FAIL mid_stay_idle: got busy=%b done=%b pi=%0d expected 0 0 0", busy, done, pi_out); end
        run_sweep(1'b0, edges, seq_err);
        checks++; if (edges != 129 || seq_err != 0) begin failures++; $display("FAIL mid_rerun_timing: got edges=%0d seq_err=%0d expected 129 0", edges, seq_err); end
        checks++; if (int'(mismatch_cnt) != exp_mm || int'(hd_sum) != exp_hd) begin failures++; $display("FAIL mid_rerun_mm_hd: got %0d %0d expected %0d %0d", mismatch_cnt, hd_sum, exp_mm, exp_hd); end
        checks++; if (int'(abs_err_sum) != exp_abs || int'(max_abs_err) != exp_max) begin failures++; $display("FAIL mid_rerun_abs_max: got %0d %0d expected %0d %0d", abs_err_sum, max_abs_err, exp_abs, exp_max); end
    endtask

    initial begin
        test_reset();
        test_identical();
        test_zero_approx();
        test_lsb_flip();
        test_random();
        test_back_to_back();
        test_reset_midsweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
